// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DIV_N = 8;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for seq_divider.
interface seq_divider_if #(parameter int N = 8);

    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_div_sub_stage.sv
// Combinational trial subtractor: diff = a - b with borrow out, same borrow
// semantics as the add/sub datapath.
module div_sub_stage #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one trial subtract per clock,
// N clocks per divide, start/done handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int CW = cnt_width(N);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    rem_sh;
    logic [N:0]    trial;
    logic          borrow;
    logic          take;

    assign rem_sh = {rem_q, q_q[N-1]};

    div_sub_stage #(.W(N+1)) u_sub (
        .a      (rem_sh),
        .b      ({1'b0, dvs_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    // With rem < divisor held as an invariant, a borrow-free trial always fits N bits.
    assign take = ~borrow & ~trial[N];

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves a signal unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dvs_d   = bus.divisor;
                    q_d     = bus.dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dvs_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = q_q;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    q_d   = {q_q[N-2:0], take};
                    rem_d = take ? trial[N-1:0] : rem_sh[N-1:0];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N-1)) begin
                        quotient_d  = q_d;
                        remainder_d = rem_d;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
